operand_entry: RTL and testbench

OPERAND_ENTRY -- requirements
Module: operand_entry

---
 rtl/calc_pkg.sv | 26 ++
 rtl/key_debounce.sv | 107 ++++++++++
 rtl/operand_entry.sv | 103 ++++++++++
 tb/tb_operand_entry.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the operand-entry calculator front end.
// Holds the operand type, key debounce FSM states, switch select positions and counter sizing.
package calc_pkg;

    typedef logic [3:0] nibble_t;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam int SW_SEL_A = 9;
    localparam int SW_SEL_B = 8;

    function automatic int max_int(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    // The counter must reach the longer of the two periods without wrapping.
    function automatic int cnt_width(input int db, input int rp);
        return $clog2(max_int(db, rp) + 1);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer plus 4-state debounce FSM for one active-low key.
// Latency: press_o fires 2 + DEBOUNCE_CYCLES cycles after a stable low; no backpressure.
module key_debounce
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 25000000,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic press_o
);

    localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(max_int(DEBOUNCE_CYCLES, REPEAT_CYCLES));
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             key_low;
    key_state_t       state_q;
    key_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    // Synchronizer resets to the released (high) level so reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
        end
    end

    assign key_low = ~sync2_q;
    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_o = 1'b0;
        case (state_q)
            RELEASED: begin
                if (key_low) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!key_low) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_o = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            PRESSED: begin
                if (!key_low) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (REPEAT_EN && (cnt_q == RP_LAST)) begin
                    cnt_d   = '0;
                    press_o = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RELEASE_WAIT: begin
                if (key_low) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/operand_entry.sv
// operand_entry: debounced load/clear keys write 4-bit operands A/B from switches; no backpressure.
// Event 2 + DEBOUNCE_CYCLES cycles after a key press; AUTO_REPEAT_EN adds load auto-repeat.
module operand_entry
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] key_n,
    input  logic [9:0] sw,
    output nibble_t    a,
    output nibble_t    b,
    output logic       load_pulse,
    output logic       clear_pulse
);

`ifdef AUTO_REPEAT_EN
    localparam bit LOAD_REPEAT = 1'b1;
`else
    localparam bit LOAD_REPEAT = 1'b0;
`endif

    logic       load_evt;
    logic       clear_evt;
    logic [5:0] sw_s1_q;
    logic [5:0] sw_s2_q;
    logic       sw_unused;
    logic       sel_a;
    logic       sel_b;
    nibble_t    sw_val;
    nibble_t    a_q;
    nibble_t    a_d;
    nibble_t    b_q;
    nibble_t    b_d;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .REPEAT_EN       (LOAD_REPEAT)
    ) u_load_key (
        .clk     (clk),
        .rst     (rst),
        .key_n_i (key_n[1]),
        .press_o (load_evt)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .REPEAT_EN       (1'b0)
    ) u_clear_key (
        .clk     (clk),
        .rst     (rst),
        .key_n_i (key_n[0]),
        .press_o (clear_evt)
    );

    // Switches share the key synchronizer depth so the value seen in the event cycle is aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
        end else begin
            sw_s1_q <= {sw[SW_SEL_A], sw[SW_SEL_B], sw[3:0]};
            sw_s2_q <= sw_s1_q;
        end
    end

    assign sw_unused = ^sw[7:4];
    assign sel_a     = sw_s2_q[5];
    assign sel_b     = sw_s2_q[4];
    assign sw_val    = sw_s2_q[3:0];

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (clear_evt) begin
            a_d = '0;
            b_d = '0;
        end else if (load_evt) begin
            if (sel_a) a_d = sw_val;
            if (sel_b) b_d = sw_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign a           = a_q;
    assign b           = b_q;
    assign clear_pulse = clear_evt;
    assign load_pulse  = load_evt & ~clear_evt;

endmodule

// File: tb/tb_operand_entry.sv
// tb_operand_entry: directed key/switch scenarios with a queued scoreboard of expected events.
// A negedge monitor pops one expectation per pulse and checks kind, cycle and resulting operands.
module tb_operand_entry;

    localparam int DB  = 4;
    localparam int RP  = 10;
    localparam int LAT = 2 + DB;

    logic       clk;
    logic       rst;
    logic [1:0] key_n;
    logic [9:0] sw;
    logic [3:0] a;
    logic [3:0] b;
    logic       load_pulse;
    logic       clear_pulse;

    int total;
    int bad;
    int cyc;

    typedef struct {
        bit         is_clr;
        int         cyc;
        logic [3:0] ea;
        logic [3:0] eb;
    } exp_t;

    exp_t       exp_q[$];
    bit         ab_pend;
    logic [3:0] pa;
    logic [3:0] pb;

    operand_entry #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_CYCLES   (RP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_n),
        .sw          (sw),
        .a           (a),
        .b           (b),
        .load_pulse  (load_pulse),
        .clear_pulse (clear_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Monitor: checks operands one cycle after each pulse, then consumes the next expectation.
    always @(negedge clk) begin
        exp_t e;
        if (ab_pend) begin
            chk("ev_a", int'(a), int'(pa));
            chk("ev_b", int'(b), int'(pb));
            ab_pend = 1'b0;
        end
        if (load_pulse || clear_pulse) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse load=%0b clear=%0b cycle=%0d", load_pulse, clear_pulse, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("ev_kind", int'({clear_pulse, load_pulse}), e.is_clr ? 2 : 1);
                chk("ev_cycle", cyc, e.cyc);
                pa      = e.ea;
                pb      = e.eb;
                ab_pend = 1'b1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input bit clr, input int at, input logic [3:0] ea, input logic [3:0] eb);
        exp_t e;
        e.is_clr = clr;
        e.cyc    = at;
        e.ea     = ea;
        e.eb     = eb;
        exp_q.push_back(e);
    endtask

    // Press one key for 'hold' cycles expecting a single event, then release and let it settle.
    task automatic press(input int idx, input int hold, input bit clr,
                         input logic [3:0] ea, input logic [3:0] eb, input string nm);
        key_n[idx] = 1'b0;
        expect_ev(clr, cyc + LAT, ea, eb);
        step(hold);
        key_n[idx] = 1'b1;
        step(12);
        chk({nm, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        ab_pend = 1'b0;
        pa      = '0;
        pb      = '0;
        rst     = 1'b1;
        key_n   = 2'b11;
        sw      = 10'h000;
        #1;
        step(3);
        chk("rst_a", int'(a), 0);
        chk("rst_b", int'(b), 0);
        chk("rst_load_pulse", int'(load_pulse), 0);
        chk("rst_clear_pulse", int'(clear_pulse), 0);
        rst = 1'b0;
        step(3);

        // Load into A only; 8-cycle hold yields a single event.
        sw = 10'h205;
        step(3);
        press(1, 8, 1'b0, 4'h5, 4'h0, "load_a");
        chk("load_a_a", int'(a), 5);
        chk("load_a_b", int'(b), 0);

        // Bouncing load key never holds low long enough.
        sw = 10'h30F;
        for (int i = 0; i < 5; i++) begin
            key_n[1] = 1'b0;
            step(2);
            key_n[1] = 1'b1;
            step(2);
        end
        step(10);
        chk("bounce_a", int'(a), 5);
        chk("bounce_b", int'(b), 0);
        chk("bounce_drained", exp_q.size(), 0);

        // Load both, then clear.
        sw = 10'h30A;
        step(3);
        press(1, 8, 1'b0, 4'hA, 4'hA, "load_ab");
        press(0, 8, 1'b1, 4'h0, 4'h0, "clear");
        chk("clear_a", int'(a), 0);
        chk("clear_b", int'(b), 0);

        // Simultaneous keys: clear wins even with both selects set.
        sw = 10'h307;
        step(3);
        press(1, 8, 1'b0, 4'h7, 4'h7, "load_77");
        key_n = 2'b00;
        expect_ev(1'b1, cyc + LAT, 4'h0, 4'h0);
        step(8);
        key_n = 2'b11;
        step(12);
        chk("both_a", int'(a), 0);
        chk("both_b", int'(b), 0);
        chk("both_drained", exp_q.size(), 0);

        // Reset during PRESS_WAIT with the key still held.
        sw = 10'h30C;
        step(3);
        press(1, 8, 1'b0, 4'hC, 4'hC, "load_cc");
        sw = 10'h201;
        step(3);
        key_n[1] = 1'b0;
        step(5);
        rst = 1'b1;
        step(1);
        chk("midrst_a", int'(a), 0);
        chk("midrst_b", int'(b), 0);
        chk("midrst_load_pulse", int'(load_pulse), 0);
        chk("midrst_clear_pulse", int'(clear_pulse), 0);
        step(1);
        rst = 1'b0;
        expect_ev(1'b0, cyc + LAT, 4'h1, 4'h0);
        step(10);
        key_n[1] = 1'b1;
        step(12);
        chk("midrst_drained", exp_q.size(), 0);
        chk("midrst_final_a", int'(a), 1);

        // Long hold: auto-repeat only when compiled in.
        sw = 10'h10E;
        step(3);
        key_n[1] = 1'b0;
        begin
            int c0;
            c0 = cyc;
            expect_ev(1'b0, c0 + LAT, 4'h1, 4'hE);
`ifdef AUTO_REPEAT_EN
            for (int k = 1; k < 4; k++) expect_ev(1'b0, c0 + LAT + k * RP, 4'h1, 4'hE);
`endif
        end
        step(40);
        key_n[1] = 1'b1;
        step(15);
        chk("hold_drained", exp_q.size(), 0);
        chk("hold_a", int'(a), 1);
        chk("hold_b", int'(b), 14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
